// File: rtl/adder_disp_pkg.sv
// rtl/adder_disp_pkg.sv - shared constants and helpers for the BCD adder display
// Purpose: FSM state encodings, the 7-segment digit table and the BCD-digit to
//          segment mapping used by adder_bcd_display_seq.
// Ports:   none (package).
package adder_disp_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CONV_A = 3'd1;
  localparam logic [2:0] CONV_B = 3'd2;
  localparam logic [2:0] CONV_S = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  // bit0 = a .. bit6 = g, active-high
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [6:0] SEG_ZERO = 7'h3F;

  // Codes 10-15 cannot come out of the converter; they map to a blank digit.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] seg;
    seg = 7'h00;
    for (int i = 0; i < 10; i++) begin
      if (d == 4'(i)) seg = SEG_DIGIT[i];
    end
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// rtl/bin2bcd_dd.sv - sequential double-dabble binary to BCD converter
// Purpose: converts an IN_W-bit unsigned value to DIG BCD digits, one input bit
//          per clock, MSB first.
// Ports:   clk, rst_n (sync, active-low); start loads bin and shifts in its MSB;
//          done is high in the cycle whose clock edge performs the final shift,
//          and bcd presents the completed result during that cycle.
module bin2bcd_dd #(
  parameter int IN_W = 8,
  parameter int DIG  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IN_W-1:0]   bin,
  output logic              done,
  output logic [4*DIG-1:0]  bcd
);

  localparam int CNT_W = $clog2(IN_W);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(IN_W - 1);

  logic [IN_W-1:0]  sh_q;
  logic [4*DIG-1:0] bcd_q;
  logic [4*DIG-1:0] adj;
  logic [4*DIG-1:0] bcd_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  // Add 3 to any digit >= 5 before the shift so it carries correctly.
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < DIG; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    bcd_nxt = (adj << 1) | {{(4*DIG-1){1'b0}}, sh_q[IN_W-1]};
  end

  // Exposing the combinational final step lets the caller capture the result
  // and restart the core on the same edge.
  assign done = run_q && (cnt_q == CNT_W'(1));
  assign bcd  = bcd_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      // A single bit shifted into an all-zero BCD never needs correction.
      sh_q  <= bin << 1;
      bcd_q <= {{(4*DIG-1){1'b0}}, bin[IN_W-1]};
      cnt_q <= CNT_INIT;
      run_q <= 1'b1;
    end else if (run_q) begin
      sh_q  <= sh_q << 1;
      bcd_q <= bcd_nxt;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/adder_bcd_display_seq.sv
// rtl/adder_bcd_display_seq.sv - switch-entry adder with sequential BCD 7-segment display
// Purpose: holds operands A/B loaded from slide switches, converts A, B and the
//          result to BCD with one shared double-dabble core, and drives
//          registered 7-segment buses that all update together.
// Ports:   clk, rst_n (sync, active-low); switchs/switch_mode/load operand entry;
//          busy (conversion running, load ignored); valid (one-cycle pulse on
//          display update); seg_a/seg_b/seg_sum digit k at [7k+6:7k], k=0 units.
// Config:  ADDER_SUB_EN adds op_sub (sampled with load; result = |A-B|) and
//          sum_neg (A<B during a subtraction, updates with seg_sum).
module adder_bcd_display_seq
  import adder_disp_pkg::*;
#(
  parameter int OP_W    = 7,
  parameter int OP_DIG  = 3,
  parameter int SUM_DIG = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OP_W-1:0]      switchs,
  input  logic                 switch_mode,
  input  logic                 load,
`ifdef ADDER_SUB_EN
  input  logic                 op_sub,
  output logic                 sum_neg,
`endif
  output logic                 busy,
  output logic                 valid,
  output logic [7*OP_DIG-1:0]  seg_a,
  output logic [7*OP_DIG-1:0]  seg_b,
  output logic [7*SUM_DIG-1:0] seg_sum
);

  logic [2:0]           state;
  logic [OP_W-1:0]      op_a;
  logic [OP_W-1:0]      op_b;
  logic                 kick;
  logic                 commit;
  logic [OP_W:0]        result;
  logic [4*OP_DIG-1:0]  shadow_a;
  logic [4*OP_DIG-1:0]  shadow_b;
  logic [4*SUM_DIG-1:0] shadow_s;
  logic                 cv_start;
  logic                 cv_done;
  logic [OP_W:0]        cv_bin;
  logic [4*SUM_DIG-1:0] cv_bcd;

`ifdef ADDER_SUB_EN
  logic sub_q;

  always_comb begin
    result = {1'b0, op_a} + {1'b0, op_b};
    if (sub_q) begin
      result = (op_a < op_b) ? ({1'b0, op_b} - {1'b0, op_a})
                             : ({1'b0, op_a} - {1'b0, op_b});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sub_q   <= 1'b0;
      sum_neg <= 1'b0;
    end else begin
      if (state == IDLE && load) sub_q <= op_sub;
      if (state == CONV_S && commit) sum_neg <= sub_q && (op_a < op_b);
    end
  end
`else
  assign result = {1'b0, op_a} + {1'b0, op_b};
`endif

  // kick starts A in the first CONV_A cycle from the freshly loaded register;
  // B and the result are chained onto the previous conversion's final edge.
  assign cv_start = kick | (cv_done & ((state == CONV_A) | (state == CONV_B)));
  assign cv_bin   = kick ? {1'b0, op_a} : ((state == CONV_A) ? {1'b0, op_b} : result);

  bin2bcd_dd #(
    .IN_W (OP_W + 1),
    .DIG  (SUM_DIG)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (cv_start),
    .bin   (cv_bin),
    .done  (cv_done),
    .bcd   (cv_bcd)
  );

  assign busy  = (state != IDLE);
  assign valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      kick     <= 1'b0;
      commit   <= 1'b0;
      shadow_a <= '0;
      shadow_b <= '0;
      shadow_s <= '0;
      seg_a    <= {OP_DIG{SEG_ZERO}};
      seg_b    <= {OP_DIG{SEG_ZERO}};
      seg_sum  <= {SUM_DIG{SEG_ZERO}};
    end else begin
      kick   <= 1'b0;
      commit <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            if (switch_mode) op_a <= switchs;
            else             op_b <= switchs;
            kick  <= 1'b1;
            state <= CONV_A;
          end
        end
        CONV_A: begin
          if (cv_done) begin
            shadow_a <= cv_bcd[4*OP_DIG-1:0];
            state    <= CONV_B;
          end
        end
        CONV_B: begin
          if (cv_done) begin
            shadow_b <= cv_bcd[4*OP_DIG-1:0];
            state    <= CONV_S;
          end
        end
        CONV_S: begin
          // Result lands in its shadow first; all displays switch one edge later.
          if (commit) begin
            for (int k = 0; k < OP_DIG; k++) begin
              seg_a[7*k +: 7] <= bcd_to_seg(shadow_a[4*k +: 4]);
              seg_b[7*k +: 7] <= bcd_to_seg(shadow_b[4*k +: 4]);
            end
            for (int k = 0; k < SUM_DIG; k++) begin
              seg_sum[7*k +: 7] <= bcd_to_seg(shadow_s[4*k +: 4]);
            end
            state <= DONE;
          end else if (cv_done) begin
            shadow_s <= cv_bcd;
            commit   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
